// File: rtl/scbuf_fbd_fill_asm_if.sv
// Fill-buffer write-assembly interface.
// Groups the DRAM fill input, the OFF-mode store request/ready, the array
// read request with its fan-out/hazard outputs, and the registered r3 array
// write port.
//   slave  : the assembler (scbuf_fbd_fill_asm)
//   master : the requester/array side that drives fills, stores and reads
interface scbuf_fbd_fill_asm_if #(
    parameter int ENTRIES = 8,
    parameter int BEATS   = 4,
    parameter int WORDS   = 4,
    parameter int NCOPY   = 4
);
    localparam int EW     = $clog2(ENTRIES);
    localparam int BW     = $clog2(BEATS);
    localparam int BEAT_W = 39 * WORDS;
    localparam int NW     = BEATS * WORDS;

    // DRAM fill beat
    logic                  fill_vld_r2;
    logic [EW-1:0]         fill_wl_r2;
    logic [32*WORDS-1:0]   fill_data_r2;
    logic [7*WORDS-1:0]    fill_ecc_r2;
    // OFF-mode store
    logic                  st_vld_c3;
    logic [EW-1:0]         st_wl_c3;
    logic [BW-1:0]         st_beat_c3;
    logic                  st_half_c3;
    logic [77:0]           st_decc_c3;
    logic                  st_rdy_c3;
    // array read
    logic                  rd_en_c3;
    logic [EW-1:0]         rd_wl_c3;
    logic [NCOPY-1:0]      rd_en_c3_v;
    logic [NCOPY*EW-1:0]   rd_wl_c3_v;
    logic                  rd_hazard_c3;
    // array write port (r3)
    logic [NW-1:0]         fbwr_wen_r3;
    logic [NCOPY-1:0]      fbwr_wren_r3;
    logic [NCOPY*EW-1:0]   fbwr_wl_r3_v;
    logic [BEATS*BEAT_W-1:0] fb_array_din;
    logic                  fill_done_r3;
    logic [EW-1:0]         fill_done_wl_r3;

    modport slave (
        input  fill_vld_r2, fill_wl_r2, fill_data_r2, fill_ecc_r2,
        input  st_vld_c3, st_wl_c3, st_beat_c3, st_half_c3, st_decc_c3,
        output st_rdy_c3,
        input  rd_en_c3, rd_wl_c3,
        output rd_en_c3_v, rd_wl_c3_v, rd_hazard_c3,
        output fbwr_wen_r3, fbwr_wren_r3, fbwr_wl_r3_v, fb_array_din,
        output fill_done_r3, fill_done_wl_r3
    );

    modport master (
        output fill_vld_r2, fill_wl_r2, fill_data_r2, fill_ecc_r2,
        output st_vld_c3, st_wl_c3, st_beat_c3, st_half_c3, st_decc_c3,
        input  st_rdy_c3,
        output rd_en_c3, rd_wl_c3,
        input  rd_en_c3_v, rd_wl_c3_v, rd_hazard_c3,
        input  fbwr_wen_r3, fbwr_wren_r3, fbwr_wl_r3_v, fb_array_din,
        input  fill_done_r3, fill_done_wl_r3
    );
endinterface

// File: rtl/scbuf_fbd_fill_asm.sv
// Fill-buffer write assembler.
// Turns DRAM fill beats and OFF-mode stores into per-word write enables,
// replicated write data and entry-select copies for the fill-buffer array,
// one cycle later (r3). Tracks a beat counter and in-progress flag per entry
// so fills to different entries can interleave, pulses fill_done_r3 when an
// entry's last beat is written, and flags reads of entries still filling.
// Ports:
//   rclk : clock, rising edge
//   arst : asynchronous reset, active high
//   fb   : scbuf_fbd_fill_asm_if.slave (fill, store, read, array write port)
// The parameters must match those of the connected interface instance.
module scbuf_fbd_fill_asm #(
    parameter int ENTRIES = 8,
    parameter int BEATS   = 4,
    parameter int WORDS   = 4,
    parameter int NCOPY   = 4
) (
    input  logic rclk,
    input  logic arst,
    scbuf_fbd_fill_asm_if.slave fb
);
    localparam int EW     = $clog2(ENTRIES);
    localparam int BW     = $clog2(BEATS);
    localparam int BEAT_W = 39 * WORDS;
    localparam int NW     = BEATS * WORDS;
    localparam int G      = NW / NCOPY;

    logic [BW-1:0]           cnt [ENTRIES];
    logic [ENTRIES-1:0]      busy;

    logic [BEAT_W-1:0]       beat;
    logic                    fill_acc;
    logic                    st_acc;
    logic [BW-1:0]           fbeat;
    logic                    fill_last;

    logic [NW-1:0]           wen_nxt;
    logic [NCOPY-1:0]        wren_nxt;
    logic [BEATS*BEAT_W-1:0] din_nxt;
    logic [EW-1:0]           wl_nxt;

    logic [NW-1:0]           wen_q;
    logic [NCOPY-1:0]        wren_q;
    logic [BEATS*BEAT_W-1:0] din_q;
    logic [EW-1:0]           wl_q;
    logic                    done_q;
    logic [EW-1:0]           done_wl_q;

    // word i = {data_i, ecc_i}, highest word at the MSB end
    for (genvar i = 0; i < WORDS; i++) begin : g_pack
        assign beat[39*i +: 39] = {fb.fill_data_r2[32*i +: 32], fb.fill_ecc_r2[7*i +: 7]};
    end

    // fill always wins; a blocked store simply sees st_rdy low and retries
    assign fill_acc  = fb.fill_vld_r2;
    assign st_acc    = fb.st_vld_c3 & ~fb.fill_vld_r2;
    assign fbeat     = cnt[fb.fill_wl_r2];
    assign fill_last = (fbeat == BW'(BEATS - 1));

    always_comb begin
        wen_nxt = '0;
        din_nxt = '0;
        wl_nxt  = wl_q;
        if (fill_acc) begin
            wen_nxt[int'(fbeat)*WORDS +: WORDS] = '1;
            din_nxt = {BEATS{beat}};
            wl_nxt  = fb.fill_wl_r2;
        end else if (st_acc) begin
            // a store covers one word pair; the 78b payload is tiled across every pair
            wen_nxt[int'(fb.st_beat_c3)*WORDS + 2*int'(fb.st_half_c3) +: 2] = 2'b11;
            din_nxt = {(NW/2){fb.st_decc_c3}};
            wl_nxt  = fb.st_wl_c3;
        end
    end

    for (genvar k = 0; k < NCOPY; k++) begin : g_wren
        assign wren_nxt[k] = |wen_nxt[k*G +: G];
    end

    // per-entry beat tracking
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            for (int e = 0; e < ENTRIES; e++) cnt[e] <= '0;
            busy <= '0;
        end else if (fill_acc) begin
            cnt[fb.fill_wl_r2]  <= fill_last ? '0 : fbeat + 1'b1;
            busy[fb.fill_wl_r2] <= ~fill_last;
        end
    end

    // r3 write port
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            wen_q     <= '0;
            wren_q    <= '0;
            din_q     <= '0;
            wl_q      <= '0;
            done_q    <= 1'b0;
            done_wl_q <= '0;
        end else begin
            wen_q  <= wen_nxt;
            wren_q <= wren_nxt;
            din_q  <= din_nxt;
            wl_q   <= wl_nxt;
            done_q <= fill_acc & fill_last;
            if (fill_acc & fill_last) done_wl_q <= fb.fill_wl_r2;
        end
    end

    assign fb.st_rdy_c3       = st_acc;
    assign fb.rd_en_c3_v      = {NCOPY{fb.rd_en_c3}};
    assign fb.rd_wl_c3_v      = {NCOPY{fb.rd_wl_c3}};
    // sees only committed state: a fill beat in the same cycle is not yet counted
    assign fb.rd_hazard_c3    = fb.rd_en_c3 & busy[fb.rd_wl_c3];
    assign fb.fbwr_wen_r3     = wen_q;
    assign fb.fbwr_wren_r3    = wren_q;
    assign fb.fbwr_wl_r3_v    = {NCOPY{wl_q}};
    assign fb.fb_array_din    = din_q;
    assign fb.fill_done_r3    = done_q;
    assign fb.fill_done_wl_r3 = done_wl_q;
endmodule

// File: tb/tb_scbuf_fbd_fill_asm.sv
module tb_scbuf_fbd_fill_asm;
    logic rclk = 1'b0;
    logic arst = 1'b0;
    bit   go   = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 rclk = ~rclk;

    scbuf_fbd_fill_asm_if #(.ENTRIES(8), .BEATS(4), .WORDS(4), .NCOPY(4)) fb ();
    scbuf_fbd_fill_asm #(.ENTRIES(8), .BEATS(4), .WORDS(4), .NCOPY(4)) dut (
        .rclk(rclk), .arst(arst), .fb(fb));

    scbuf_fbd_fill_asm_if #(.ENTRIES(16), .BEATS(8), .WORDS(2), .NCOPY(8)) fb2 ();
    scbuf_fbd_fill_asm #(.ENTRIES(16), .BEATS(8), .WORDS(2), .NCOPY(8)) dut2 (
        .rclk(rclk), .arst(arst), .fb(fb2));

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- model of the default-parameter instance ----------------
    int          m_cnt [8];
    bit          m_busy [8];
    logic [15:0] e_wen;
    logic [3:0]  e_wren;
    logic [2:0]  e_wl;
    logic [623:0] e_din;
    logic        e_done;
    logic [2:0]  e_done_wl;

    task automatic m_reset();
        for (int e = 0; e < 8; e++) begin m_cnt[e] = 0; m_busy[e] = 0; end
        e_wen = '0; e_wren = '0; e_wl = '0; e_din = '0; e_done = 0; e_done_wl = '0;
    endtask

    task automatic m_step();
        int b;
        int w0;
        e_wen = '0; e_wren = '0; e_din = '0; e_done = 0;
        if (fb.fill_vld_r2 === 1'b1) begin
            b = m_cnt[fb.fill_wl_r2];
            for (int w = 0; w < 4; w++) e_wen[b*4 + w] = 1'b1;
            for (int k = 0; k < 16; k++)
                e_din[39*k +: 39] = {fb.fill_data_r2[32*(k%4) +: 32], fb.fill_ecc_r2[7*(k%4) +: 7]};
            e_wl = fb.fill_wl_r2;
            if (b == 3) begin
                m_cnt[fb.fill_wl_r2] = 0; m_busy[fb.fill_wl_r2] = 0;
                e_done = 1; e_done_wl = fb.fill_wl_r2;
            end else begin
                m_cnt[fb.fill_wl_r2] = b + 1; m_busy[fb.fill_wl_r2] = 1;
            end
        end else if (fb.st_vld_c3 === 1'b1) begin
            w0 = int'(fb.st_beat_c3) * 4 + 2 * int'(fb.st_half_c3);
            e_wen[w0] = 1'b1; e_wen[w0 + 1] = 1'b1;
            for (int k = 0; k < 8; k++) e_din[78*k +: 78] = fb.st_decc_c3;
            e_wl = fb.st_wl_c3;
        end
        for (int w = 0; w < 16; w++) if (e_wen[w]) e_wren[w/4] = 1'b1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge rclk or posedge arst);
            if (arst) m_reset(); else m_step();
        end
    end

    // every-cycle comparison, away from the rising edge
    initial begin
        forever begin
            @(negedge rclk);
            if (go) begin
                chk("m_wen",  fb.fbwr_wen_r3,  e_wen);
                chk("m_wren", fb.fbwr_wren_r3, e_wren);
                chk("m_din",  fb.fb_array_din, e_din);
                chk("m_wl_v", fb.fbwr_wl_r3_v, {4{e_wl}});
                chk("m_done", fb.fill_done_r3, e_done);
                if (e_done) chk("m_done_wl", fb.fill_done_wl_r3, e_done_wl);
                chk("m_st_rdy", fb.st_rdy_c3, fb.st_vld_c3 & ~fb.fill_vld_r2);
                chk("m_hazard", fb.rd_hazard_c3, fb.rd_en_c3 & m_busy[fb.rd_wl_c3]);
                chk("m_rd_en_v", fb.rd_en_c3_v, {4{fb.rd_en_c3}});
                chk("m_rd_wl_v", fb.rd_wl_c3_v, {4{fb.rd_wl_c3}});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge rclk); #1;
    endtask

    task automatic idle();
        fb.fill_vld_r2 = 0; fb.st_vld_c3 = 0; fb.rd_en_c3 = 0;
        fb2.fill_vld_r2 = 0; fb2.st_vld_c3 = 0; fb2.rd_en_c3 = 0;
    endtask

    task automatic fill(input logic [2:0] wl);
        fb.fill_vld_r2  = 1;
        fb.fill_wl_r2   = wl;
        fb.fill_data_r2 = {$urandom, $urandom, $urandom, $urandom};
        fb.fill_ecc_r2  = 28'($urandom);
        tick();
    endtask

    initial begin
        fb.fill_wl_r2 = '0; fb.fill_data_r2 = '0; fb.fill_ecc_r2 = '0;
        fb.st_wl_c3 = '0; fb.st_beat_c3 = '0; fb.st_half_c3 = 0; fb.st_decc_c3 = '0; fb.rd_wl_c3 = '0;
        fb2.fill_wl_r2 = '0; fb2.fill_data_r2 = '0; fb2.fill_ecc_r2 = '0;
        fb2.st_wl_c3 = '0; fb2.st_beat_c3 = '0; fb2.st_half_c3 = 0; fb2.st_decc_c3 = '0; fb2.rd_wl_c3 = '0;
        idle();
        #2 arst = 1;
        #10;
        chk("rst_wen",  fb.fbwr_wen_r3, 16'h0);
        chk("rst_done", fb.fill_done_r3, 1'b0);
        chk("rst_wl_v", fb.fbwr_wl_r3_v, 12'h0);
        chk("rst_din",  fb.fb_array_din, 624'h0);
        @(posedge rclk); #1 arst = 0; go = 1;

        // four beats to entry 3, first beat with known data
        fb.fill_vld_r2  = 1;
        fb.fill_wl_r2   = 3'd3;
        fb.fill_data_r2 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        fb.fill_ecc_r2  = {7'h44, 7'h33, 7'h22, 7'h11};
        tick();
        chk("f3_wen0", fb.fbwr_wen_r3, 16'h000F);
        chk("f3_din_w0", fb.fb_array_din[38:0], 39'h08_8888_8891);
        chk("f3_din_top", fb.fb_array_din[623:585], 39'h22_2222_2244);
        chk("f3_done0", fb.fill_done_r3, 1'b0);
        fill(3'd3); chk("f3_wen1", fb.fbwr_wen_r3, 16'h00F0);
        fill(3'd3); chk("f3_wen2", fb.fbwr_wen_r3, 16'h0F00);
        chk("f3_done2", fb.fill_done_r3, 1'b0);
        fill(3'd3); chk("f3_wen3", fb.fbwr_wen_r3, 16'hF000);
        chk("f3_done3", fb.fill_done_r3, 1'b1);
        chk("f3_done_wl", fb.fill_done_wl_r3, 3'd3);
        chk("f3_wren", fb.fbwr_wren_r3, 4'b1000);
        idle(); tick();
        chk("idle_wen", fb.fbwr_wen_r3, 16'h0);
        chk("idle_wl_hold", fb.fbwr_wl_r3_v, {4{3'd3}});

        // store colliding with a fill, then store alone
        fb.st_vld_c3 = 1; fb.st_wl_c3 = 3'd2; fb.st_beat_c3 = 2'd2; fb.st_half_c3 = 1;
        fb.st_decc_c3 = 78'h2A5A_5A5A_5A5A_5A5A_5A5C;
        fb.fill_vld_r2 = 1; fb.fill_wl_r2 = 3'd4; fb.fill_data_r2 = {4{32'hCAFE_F00D}}; fb.fill_ecc_r2 = '0;
        #1 chk("st_rdy_blk", fb.st_rdy_c3, 1'b0);
        tick();
        chk("st_fill_only", fb.fbwr_wen_r3, 16'h000F);
        fb.fill_vld_r2 = 0;
        #1 chk("st_rdy_ok", fb.st_rdy_c3, 1'b1);
        tick();
        chk("st_wen", fb.fbwr_wen_r3, 16'h0C00);
        chk("st_wren", fb.fbwr_wren_r3, 4'b0100);
        chk("st_wl", fb.fbwr_wl_r3_v, {4{3'd2}});
        chk("st_din", fb.fb_array_din[77:0], 78'h2A5A_5A5A_5A5A_5A5A_5A5C);
        idle();

        // read hazard
        fill(3'd1); fill(3'd1); idle();
        fb.rd_en_c3 = 1; fb.rd_wl_c3 = 3'd1;
        #1 chk("hz_e1", fb.rd_hazard_c3, 1'b1);
        fb.rd_wl_c3 = 3'd2;
        #1 chk("hz_e2", fb.rd_hazard_c3, 1'b0);
        fb.rd_wl_c3 = 3'd4;
        #1 chk("hz_e4", fb.rd_hazard_c3, 1'b1);
        fb.rd_en_c3 = 0;
        #1 chk("hz_noen", fb.rd_hazard_c3, 1'b0);
        tick();
        fill(3'd1); fill(3'd1);
        chk("hz_e1_done", fb.fill_done_r3, 1'b1);
        idle();
        fb.rd_en_c3 = 1; fb.rd_wl_c3 = 3'd1;
        #1 chk("hz_e1_clear", fb.rd_hazard_c3, 1'b0);
        fb.rd_en_c3 = 0;
        tick();

        // same-cycle fill not yet visible to the hazard check
        fb.rd_en_c3 = 1; fb.rd_wl_c3 = 3'd7;
        fb.fill_vld_r2 = 1; fb.fill_wl_r2 = 3'd7;
        #1 chk("hz_same_cyc", fb.rd_hazard_c3, 1'b0);
        tick();
        fb.fill_vld_r2 = 0;
        #1 chk("hz_next_cyc", fb.rd_hazard_c3, 1'b1);
        idle(); tick();

        // interleaved fills to entries 0 and 5
        for (int i = 0; i < 8; i++) begin
            fill((i % 2) ? 3'd5 : 3'd0);
            chk("il_wen", fb.fbwr_wen_r3, 16'hF << (4 * (i / 2)));
            chk("il_done", fb.fill_done_r3, (i >= 6) ? 1'b1 : 1'b0);
            if (i == 6) chk("il_done_wl0", fb.fill_done_wl_r3, 3'd0);
            if (i == 7) chk("il_done_wl5", fb.fill_done_wl_r3, 3'd5);
        end
        idle(); tick();

        // reset in the middle of a fill
        fill(3'd6); fill(3'd6); fill(3'd6);
        chk("rs_wen2", fb.fbwr_wen_r3, 16'h0F00);
        idle();
        arst = 1;
        #1;
        chk("rs_wen", fb.fbwr_wen_r3, 16'h0);
        chk("rs_wren", fb.fbwr_wren_r3, 4'h0);
        chk("rs_din", fb.fb_array_din, 624'h0);
        chk("rs_done", fb.fill_done_r3, 1'b0);
        fb.rd_en_c3 = 1; fb.rd_wl_c3 = 3'd6;
        #1 chk("rs_hazard", fb.rd_hazard_c3, 1'b0);
        fb.rd_en_c3 = 0;
        tick(); tick();
        arst = 0;
        fill(3'd6);
        chk("rs_beat0", fb.fbwr_wen_r3, 16'h000F);
        chk("rs_nodone", fb.fill_done_r3, 1'b0);
        idle(); tick();

        // alternate geometry: 16 entries, 8 beats, 2 words, 8 copies
        fb2.fill_vld_r2  = 1;
        fb2.fill_wl_r2   = 4'd9;
        fb2.fill_data_r2 = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        fb2.fill_ecc_r2  = {7'h2B, 7'h1A};
        for (int b = 0; b < 8; b++) begin
            tick();
            chk("p2_wen", fb2.fbwr_wen_r3, 16'h3 << (2 * b));
            chk("p2_wren", fb2.fbwr_wren_r3, 8'h1 << b);
            chk("p2_done", fb2.fill_done_r3, (b == 7) ? 1'b1 : 1'b0);
            if (b == 0) begin
                chk("p2_din_lo", fb2.fb_array_din[77:0], {32'hBBBB_BBBB, 7'h2B, 32'hAAAA_AAAA, 7'h1A});
                chk("p2_din_hi", fb2.fb_array_din[623:546], {32'hBBBB_BBBB, 7'h2B, 32'hAAAA_AAAA, 7'h1A});
                chk("p2_wl_v", fb2.fbwr_wl_r3_v, {8{4'd9}});
            end
            if (b == 7) chk("p2_done_wl", fb2.fill_done_wl_r3, 4'd9);
        end
        idle(); tick();
        chk("p2_idle", fb2.fbwr_wen_r3, 16'h0);

        go = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
